// File: rtl/run_burst_gen.sv
// Serial burst generator: queues burst-length requests and emits each as a run of
// high cycles followed by a low gap sized so the downstream stretcher can return to idle.
module run_burst_gen #(
  parameter int LEN_W     = 5,
  parameter int DEPTH     = 4,
  parameter int CLAMP     = 24,
  parameter int GAP_EXTRA = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [LEN_W-1:0]         req_len,
  output logic                     req_ready,
  output logic                     ser_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     zero_len
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} state_t;

  state_t                      state_q;
  logic [LEN_W-1:0]            cnt_q, gap_q;
  logic                        ser_q;
  logic [DEPTH-1:0][LEN_W-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        ready_q, ready_d;
  logic                        zero_q, zero_d;
  logic                        accept, push, pop;
  logic [LEN_W-1:0]            head_len, head_gap;
  int                          clamp_i;

  assign accept   = req_valid & ready_q;
  assign push     = accept & (req_len != '0);
  assign pop      = (count_q != '0) &&
                    ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0)));
  assign head_len = mem_q[rd_ptr_q];

  // Only the gap is clamped; the burst itself always runs its full length.
  always_comb begin
    clamp_i  = (int'(head_len) > CLAMP) ? CLAMP : int'(head_len);
    head_gap = LEN_W'((clamp_i >> 2) + GAP_EXTRA);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = req_len;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Ready follows the post-edge occupancy, so a pop never frees a slot in the same cycle.
    ready_d = (count_d != CW'(DEPTH));
    zero_d  = accept & (req_len == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ser_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= HIGH;
            cnt_q   <= head_len - 1'b1;
            gap_q   <= head_gap;
            ser_q   <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= GAP;
            cnt_q   <= gap_q - 1'b1;
            ser_q   <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (pop) begin
            state_q <= HIGH;
            cnt_q   <= head_len - 1'b1;
            gap_q   <= head_gap;
            ser_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign ser_out    = ser_q;
  assign zero_len   = zero_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
endmodule
